// File: rtl/hilo_muldiv_if.sv
// EX/WB-side bundle for the HI/LO multiply/divide unit.
// The master drives the request and MTHI/MTLO writes; the slave returns stall and HI/LO.
interface hilo_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       md_op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             stall_req;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, md_op, src_a, src_b, flush, hi_we, lo_we, wdata,
    input  stall_req, hi, lo
  );

  modport slave (
    input  start, md_op, src_a, src_b, flush, hi_we, lo_we, wdata,
    output stall_req, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that owns HI/LO.
// One bit per cycle: shift-add multiply, restoring divide, with sign fix-up in DONE.
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          resetn,
  hilo_muldiv_if.slave md
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               rsign_q, rsign_d;
  logic               dsign_q, dsign_d;
  logic               nowr_q, nowr_d;
  logic               isdiv_q, isdiv_d;

  logic               sgn, a_neg, b_neg, last, done_wr;
  logic [WIDTH-1:0]   a_abs, b_abs, res_hi, res_lo;
  logic [WIDTH:0]     mul_sum, div_diff;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    sgn      = !md.md_op[0];
    a_neg    = sgn & md.src_a[WIDTH-1];
    b_neg    = sgn & md.src_b[WIDTH-1];
    a_abs    = a_neg ? -md.src_a : md.src_a;
    b_abs    = b_neg ? -md.src_b : md.src_b;
    // acc holds {partial product, multiplier} for MUL and {rem, quot} for DIV
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    prod     = rsign_q ? -acc_q : acc_q;
    if (isdiv_q) begin
      res_lo = rsign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      res_hi = dsign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end else begin
      res_lo = prod[WIDTH-1:0];
      res_hi = prod[2*WIDTH-1:WIDTH];
    end
    last = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    rsign_d = rsign_q;
    dsign_d = dsign_q;
    nowr_d  = nowr_q;
    isdiv_d = isdiv_q;
    case (state_q)
      S_IDLE: begin
        if (md.start && !md.flush) begin
          rsign_d = a_neg ^ b_neg;
          dsign_d = a_neg;
          cnt_d   = '0;
          isdiv_d = md.md_op[1];
          nowr_d  = 1'b0;
          if (md.md_op[1]) begin
            opnd_d = b_abs;
            acc_d  = {{WIDTH{1'b0}}, a_abs};
            if (md.src_b == '0) begin
              nowr_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_DIV;
            end
          end else begin
            opnd_d  = a_abs;
            acc_d   = {{WIDTH{1'b0}}, b_abs};
            state_d = S_MUL;
          end
        end
      end
      S_MUL: begin
        if (acc_q[0]) acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (last) state_d = S_DONE;
      end
      S_DIV: begin
        if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else                  acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (last) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (md.flush) state_d = S_IDLE;
  end

  // The DONE write is younger than any MTHI/MTLO in WB, so it takes priority
  always_comb begin
    done_wr = (state_q == S_DONE) && !nowr_q && !md.flush;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (md.hi_we) hi_d = md.wdata;
    if (md.lo_we) lo_d = md.wdata;
    if (done_wr) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      rsign_q <= 1'b0;
      dsign_q <= 1'b0;
      nowr_q  <= 1'b0;
      isdiv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rsign_q <= rsign_d;
      dsign_q <= dsign_d;
      nowr_q  <= nowr_d;
      isdiv_q <= isdiv_d;
    end
  end

  assign md.stall_req = resetn && !md.flush &&
                        (((state_q == S_IDLE) && md.start) ||
                         (state_q == S_MUL) || (state_q == S_DIV));
  assign md.hi = hi_q;
  assign md.lo = lo_q;
endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: hand-computed HI/LO results, stall lengths,
// flush/reset aborts and MTHI/MTLO priority.
module tb_hilo_muldiv;
  logic clk = 1'b0;
  logic resetn;
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;
  int   st;
  int   n;

  hilo_muldiv_if #(.WIDTH(32)) bus ();

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .md     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue an op in the current IDLE cycle, count stall cycles, end one cycle after DONE.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic mthi_in_done, output int stalls);
    bus.start = 1'b1; bus.md_op = op; bus.src_a = a; bus.src_b = b;
    #1;
    stalls = 0;
    while (bus.stall_req === 1'b1 && stalls < 40) begin
      stalls++;
      @(negedge clk); #1;
    end
    bus.start = 1'b0;
    bus.hi_we = mthi_in_done;
    bus.wdata = 32'hAA;
    @(negedge clk); #1;
    bus.hi_we = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    bus.start = 1'b0; bus.md_op = 2'b00; bus.src_a = '0; bus.src_b = '0;
    bus.flush = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    repeat (2) @(negedge clk); #1;
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_stall", {31'b0, bus.stall_req}, 32'h0);
    resetn = 1'b1;
    @(negedge clk); #1;

    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, st);
    chk("multu_max_stall", st, 32'd33);
    chk("multu_max_hi", bus.hi, 32'hFFFFFFFE);
    chk("multu_max_lo", bus.lo, 32'h00000001);

    do_op(2'b00, 32'hFFFFFFFD, 32'd5, 1'b0, st);
    chk("mult_neg_hi", bus.hi, 32'hFFFFFFFF);
    chk("mult_neg_lo", bus.lo, 32'hFFFFFFF1);

    do_op(2'b00, 32'h80000000, 32'h80000000, 1'b0, st);
    chk("mult_min_hi", bus.hi, 32'h40000000);
    chk("mult_min_lo", bus.lo, 32'h0);

    do_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, st);
    chk("div_neg_stall", st, 32'd33);
    chk("div_neg_lo", bus.lo, 32'hFFFFFFFD);
    chk("div_neg_hi", bus.hi, 32'hFFFFFFFF);

    do_op(2'b11, 32'd7, 32'd2, 1'b0, st);
    chk("divu_lo", bus.lo, 32'd3);
    chk("divu_hi", bus.hi, 32'd1);

    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, st);
    chk("div_ovf_lo", bus.lo, 32'h80000000);
    chk("div_ovf_hi", bus.hi, 32'h0);

    // MTHI/MTLO preload, each touching only its own register
    bus.hi_we = 1'b1; bus.wdata = 32'h11;
    @(negedge clk); #1;
    bus.hi_we = 1'b0;
    chk("mthi_hi", bus.hi, 32'h11);
    chk("mthi_lo_kept", bus.lo, 32'h80000000);
    bus.lo_we = 1'b1; bus.wdata = 32'h22;
    @(negedge clk); #1;
    bus.lo_we = 1'b0;
    chk("mtlo_lo", bus.lo, 32'h22);

    do_op(2'b11, 32'd5, 32'd0, 1'b0, st);
    chk("div0_stall", st, 32'd1);
    chk("div0_hi", bus.hi, 32'h11);
    chk("div0_lo", bus.lo, 32'h22);

    // DIV 100/7 flushed in cycle 10, then MULTU 2x3 in the following IDLE cycle
    bus.start = 1'b1; bus.md_op = 2'b10; bus.src_a = 32'd100; bus.src_b = 32'd7;
    #1;
    repeat (10) @(negedge clk); #1;
    chk("flush_busy", {31'b0, bus.stall_req}, 32'h1);
    bus.flush = 1'b1; #1;
    chk("flush_stall", {31'b0, bus.stall_req}, 32'h0);
    @(negedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_hi", bus.hi, 32'h11);
    chk("flush_lo", bus.lo, 32'h22);
    do_op(2'b01, 32'd2, 32'd3, 1'b0, st);
    chk("after_flush_stall", st, 32'd33);
    chk("after_flush_lo", bus.lo, 32'd6);
    chk("after_flush_hi", bus.hi, 32'd0);

    do_op(2'b01, 32'd4, 32'd4, 1'b1, st);
    chk("done_vs_mthi_hi", bus.hi, 32'h0);
    chk("done_vs_mthi_lo", bus.lo, 32'h10);

    // MTLO mid-divide lands at once, then the DONE write replaces it
    bus.start = 1'b1; bus.md_op = 2'b11; bus.src_a = 32'd7; bus.src_b = 32'd2;
    #1;
    repeat (5) @(negedge clk); #1;
    bus.lo_we = 1'b1; bus.wdata = 32'h55;
    @(negedge clk); #1;
    bus.lo_we = 1'b0;
    chk("mtlo_mid_lo", bus.lo, 32'h55);
    chk("mtlo_mid_hi", bus.hi, 32'h0);
    chk("mtlo_mid_stall", {31'b0, bus.stall_req}, 32'h1);
    n = 0;
    while (bus.stall_req === 1'b1 && n < 40) begin
      n++;
      @(negedge clk); #1;
    end
    bus.start = 1'b0;
    @(negedge clk); #1;
    chk("mtlo_then_done_lo", bus.lo, 32'd3);
    chk("mtlo_then_done_hi", bus.hi, 32'd1);

    // Asynchronous reset in cycle 5 of a MULT
    bus.start = 1'b1; bus.md_op = 2'b00; bus.src_a = 32'd3; bus.src_b = 32'd5;
    #1;
    repeat (5) @(negedge clk); #1;
    resetn = 1'b0; bus.start = 1'b0;
    #1;
    chk("mid_rst_hi", bus.hi, 32'h0);
    chk("mid_rst_lo", bus.lo, 32'h0);
    chk("mid_rst_stall", {31'b0, bus.stall_req}, 32'h0);
    @(negedge clk); #1;
    resetn = 1'b1;
    repeat (40) @(negedge clk); #1;
    chk("post_rst_lo", bus.lo, 32'h0);
    chk("post_rst_stall", {31'b0, bus.stall_req}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Multi-cycle multiply/divide sequencer and HI/LO register owner for the MIPS core. It accepts MULT/MULTU/DIV/DIVU from the EX stage and computes the result iteratively, one bit per cycle, with a shift-add multiplier and a restoring divider. While it computes, it holds the pipeline with a stall request, then writes HI/LO. It also services MTHI/MTLO writes and supplies HI/LO to the ALU's MFHI/MFLO path.

## Interface
- WIDTH, 32, operand/HI/LO width; even, ≥4
- clk  in  1  core clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  EX holds a mul/div instruction; held high by EX while stalled
- md_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start in IDLE
- src_a  in  WIDTH  multiplicand / dividend (rs)
- src_b  in  WIDTH  multiplier / divisor (rt)
- flush  in  1  pipeline flush (exception); aborts any operation
- hi_we  in  1  MTHI write from WB
- lo_we  in  1  MTLO write from WB
- wdata  in  WIDTH  MTHI/MTLO data
- stall_req  out  1  pipeline stall request (combinational)
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- States: IDLE, MUL, DIV, DONE. Cycle counter is log2(WIDTH)+1 bits.
- IDLE, start=1, flush=0:
  - Latch |src_a|, |src_b| for signed ops, raw values for unsigned ops.
  - Latch the result sign (a_sign XOR b_sign) and the dividend sign.
  - Clear the accumulator and counter.
  - Go to MUL (md_op[1]=0) or DIV (md_op[1]=1).
- DIV with src_b=0: go directly to DONE with the no-write flag set. HI/LO stay unchanged.
- MUL: each cycle, if multiplier bit0=1, add the multiplicand to the upper half of a 2·WIDTH accumulator (WIDTH+1-bit sum). Shift right 1. After WIDTH iterations, go to DONE.
- DIV: each cycle, shift {rem,quot} left 1 and trial-subtract the divisor from rem (WIDTH+1 bits). If non-negative, keep the difference and set quot bit0=1. After WIDTH iterations, go to DONE.
- DONE: apply sign correction, write HI/LO (unless the no-write flag is set), then return to IDLE. start is ignored in DONE because it is the same instruction.
  - MUL: {HI,LO} = product; negate the 2·WIDTH product if the result sign=1.
  - DIV: LO = quotient, negated if the result sign=1; HI = remainder, negated if the dividend sign=1.
  - All arithmetic is mod 2^WIDTH. −2^(W−1)/−1 gives LO=0x80000000, HI=0.
- stall_req = !flush && ((IDLE && start) || MUL || DIV). It is low in DONE so EX can advance.
- hi_we/lo_we write wdata in any state. If the DONE write coincides, the DONE write wins (the mul/div is younger in program order). An MTHI/MTLO alone writes only its register.
- flush, any state: next state is IDLE, no HI/LO write from the aborted op, and stall_req is 0 in that cycle. hi_we/lo_we are still honoured.

## Timing
- Reset (resetn=0, asynchronous): state=IDLE, hi=0, lo=0, counter=0, stall_req=0.
- Reset mid-operation aborts immediately; no partial write.
- Start accepted at cycle 0. Compute runs cycles 1..WIDTH, DONE is cycle WIDTH+1, and HI/LO update at the end of DONE.
- stall_req is high for cycles 0..WIDTH (WIDTH+1 cycles) and low in DONE.
- An instruction following in EX (cycle WIDTH+2) reads the new hi/lo; there is no bypass.
- Divide by zero: stall_req is high for cycle 0 only, DONE is cycle 1.
- Back-to-back: a new start is accepted in the IDLE cycle directly after DONE.
- hi/lo are registered outputs; MTHI/MTLO data is visible the cycle after hi_we/lo_we.

## Test plan
- MULTU 0xFFFFFFFF×0xFFFFFFFF -> stall_req high 33 cycles, then HI=0xFFFFFFFE, LO=0x00000001.
- MULT −3×5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULT 0x80000000×0x80000000 -> HI=0x40000000, LO=0.
- DIV −7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1. DIV 0x80000000/−1 -> LO=0x80000000, HI=0.
- Preload HI=0x11, LO=0x22 via hi_we/lo_we; DIVU 5/0 -> stall_req high 1 cycle, HI/LO stay 0x11/0x22.
- DIV 100/7 with flush at cycle 10 -> stall_req 0 that cycle, IDLE next, HI/LO unchanged. A MULTU 2×3 started the next cycle -> LO=6, HI=0.
- hi_we=1 with wdata=0xAA in the DONE cycle of MULTU 4×4 -> HI=0, LO=0x10.
- lo_we during DIV -> LO=wdata immediately, then overwritten at DONE.
- resetn low at cycle 5 of MULT -> hi=lo=0, stall_req=0, IDLE.
